// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DIVZ_QUOT    = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT     = 32'h8000_0000;
  localparam logic [31:0] OVF_REM      = 32'h0000_0000;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation of a W-bit value.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: 1 prep cycle, 32 shift-add/shift-subtract
// iterations and 1 sign fix-up cycle, completion signalled by a one-cycle fin_o.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            fin_o,
  output logic [XLEN-1:0] result_o
);

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   hi_r;
  logic [XLEN-1:0]   lo_r;
  logic              is_div_r;
  logic              neg_res_r;
  logic              neg_rem_r;
  logic              fin_r;
  logic [XLEN-1:0]   result_r;

  logic              signed_a_s;
  logic              signed_b_s;
  logic              sign_a_s;
  logic              sign_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic [XLEN:0]     mul_add_s;
  logic [XLEN+1:0]   trial_s;
  logic              no_borrow_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   sel_s;

  // Which operands are treated as signed for the latched op.
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    case (op_r)
      MD_MULH, MD_DIV, MD_REM: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b1;
      end
      MD_MULHSU: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b0;
      end
      default: begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
      end
    endcase
  end

  assign sign_a_s = signed_a_s & a_r[XLEN-1];
  assign sign_b_s = signed_b_s & b_r[XLEN-1];

  muldiv_negate #(.W(XLEN)) u_mag_a (.value(a_r), .neg(sign_a_s), .result(mag_a_s));
  muldiv_negate #(.W(XLEN)) u_mag_b (.value(b_r), .neg(sign_b_s), .result(mag_b_s));

  // Multiply step adds the multiplicand into the high half; divide step
  // tries to subtract the divisor from the remainder with the next dividend bit.
  assign mul_add_s   = {1'b0, hi_r} + (b_r[0] ? {1'b0, a_r} : {(XLEN+1){1'b0}});
  assign trial_s     = {1'b0, hi_r, a_r[XLEN-1]} - {2'b00, b_r};
  assign no_borrow_s = ~trial_s[XLEN+1];

  muldiv_negate #(.W(2*XLEN)) u_fix_prod (.value({hi_r, lo_r}), .neg(neg_res_r), .result(prod_s));
  muldiv_negate #(.W(XLEN))   u_fix_quot (.value(lo_r), .neg(neg_res_r), .result(quot_s));
  muldiv_negate #(.W(XLEN))   u_fix_rem  (.value(hi_r), .neg(neg_rem_r), .result(rem_s));

  // Final result word selected by the operation.
  always_comb begin
    sel_s = prod_s[XLEN-1:0];
    case (op_r)
      MD_MUL:                       sel_s = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: sel_s = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              sel_s = quot_s;
      MD_REM, MD_REMU:              sel_s = rem_s;
      default:                      sel_s = prod_s[XLEN-1:0];
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      op_r      <= 3'd0;
      a_r       <= '0;
      b_r       <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      fin_r     <= 1'b0;
      result_r  <= '0;
    end else begin
      fin_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // The completing instruction is still on start_i during the fin cycle.
          if (start_i && !flush_i && !fin_r) begin
            op_r      <= op_i;
            a_r       <= rs1_i;
            b_r       <= rs2_i;
            is_div_r  <= op_i[2];
            cnt_r     <= '0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            if (op_i[2] && (rs2_i == '0)) begin
              hi_r    <= rs1_i;
              lo_r    <= DIVZ_QUOT;
              state_r <= DONE;
            end else if (op_i[2] && !op_i[0] && (rs1_i == OVF_DIVIDEND) && (rs2_i == OVF_DIVISOR)) begin
              hi_r    <= OVF_REM;
              lo_r    <= OVF_QUOT;
              state_r <= DONE;
            end else begin
              hi_r    <= '0;
              lo_r    <= '0;
              state_r <= PREP;
            end
          end
        end
        PREP: begin
          if (flush_i) begin
            state_r <= IDLE;
          end else begin
            a_r       <= mag_a_s;
            b_r       <= mag_b_s;
            neg_res_r <= sign_a_s ^ sign_b_s;
            neg_rem_r <= sign_a_s;
            hi_r      <= '0;
            lo_r      <= '0;
            cnt_r     <= '0;
            state_r   <= CALC;
          end
        end
        CALC: begin
          if (flush_i) begin
            state_r <= IDLE;
          end else begin
            if (is_div_r) begin
              hi_r <= no_borrow_s ? trial_s[XLEN-1:0] : {hi_r[XLEN-2:0], a_r[XLEN-1]};
              lo_r <= {lo_r[XLEN-2:0], no_borrow_s};
              a_r  <= {a_r[XLEN-2:0], 1'b0};
            end else begin
              {hi_r, lo_r} <= {mul_add_s, lo_r[XLEN-1:1]};
              b_r          <= {1'b0, b_r[XLEN-1:1]};
            end
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == {CNT_W{1'b1}}) begin
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          if (!flush_i) begin
            result_r <= sel_s;
            fin_r    <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state_r != IDLE);
  assign fin_o    = fin_r;
  assign result_o = result_r;

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide unit in the execute stage. Source of the `fin` handshake used by the pipeline hazard/stall controller.
- Accepts a multiply or divide from decode (`is_m`/`is_d` qualified by the decoder as `start_i`) and computes it over 32 iterations.
- Pulses `fin_o` for one cycle, with the registered result, to release the front-end stall.
- Aborted by the pipeline `flush`.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- CNT_W, 5, iteration counter width: log2(XLEN).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- start_i  in  1  mul/div instruction present in decode (is_m|is_d)
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i  in  XLEN  operand A, post-bypass
- rs2_i  in  XLEN  operand B, post-bypass
- flush_i  in  1  pipeline flush from the hazard unit
- busy_o  out  1  state != IDLE
- fin_o  out  1  one-cycle completion pulse
- result_o  out  XLEN  result; valid when fin_o=1, held afterwards

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, counter=0, fin_o=0, busy_o=0, result_o=0, all internal registers 0. Reset mid-operation discards the operation and produces no fin.
- States: IDLE, PREP, CALC, DONE.
- IDLE:
  - start_i & ~flush_i -> PREP. Latch op, rs1, rs2; flag is_div = op[2].
  - Special divide cases go directly to DONE with the result preloaded:
    - rs2==0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = rs1.
    - DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - start_i with flush_i=1 is ignored.
- PREP (1 cycle):
  - Compute operand magnitudes.
  - Signed operands: MULH both, MULHSU rs1 only, DIV/REM both.
  - Result sign: mul = sA^sB; quotient = sA^sB; remainder = sA.
  - Clear the 64-bit accumulator; counter=0; -> CALC.
- CALC (exactly 32 cycles, counter 0..31):
  - Multiply: radix-2 shift-add on a 64-bit {hi,lo} accumulator, multiplier LSB first.
  - Divide: restoring shift-subtract. 33-bit trial subtract; quotient bit = no-borrow.
  - counter==31 -> DONE. Counter wrap is unused.
- DONE (1 cycle):
  - Apply negation if the result sign is set.
  - Select: low word for MUL, high word for MULH/MULHSU/MULHU, quotient or remainder for divides.
  - Register the selection into result_o; fin_o=1; -> IDLE.
- Latency from the accepting edge:
  - Normal op: fin_o high in the 35th cycle (1 PREP + 32 CALC + 1 DONE, registered).
  - Special divide cases: fin_o high in the 2nd cycle.
- start_i in DONE or while busy is ignored. Decode holds the same instruction under stall, so start_i stays high through the operation. The cycle after fin_o, IDLE may accept the next, new instruction.
- flush_i in PREP/CALC/DONE: next state IDLE, fin_o stays 0, result_o unchanged.
- flush_i and the DONE cycle together: flush wins. fin_o=0; result_o is not updated.
- fin_o is never high for two consecutive cycles.
- busy_o is combinational from the state register.
- result_o keeps its last value until the next fin_o.

Decomposition:
- Shared package `muldiv_pkg`:
  - op encodings (MD_MUL..MD_REMU, 3-bit).
  - state enum (IDLE=0, PREP=1, CALC=2, DONE=3).
  - constants for the div-by-zero and overflow results.
- One sub-module, `muldiv_negate`: conditional two's-complement of a 32- or 64-bit value. Used in PREP for magnitudes and in DONE for sign fix-up.
- The datapath core stays in the top module.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start held high -> fin_o exactly once at cycle 35, result_o=0xFFFFFFEB. busy_o high cycles 1..34.
- MULHU rs1=rs2=0xFFFFFFFF -> result_o=0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV 7/0 -> fin_o at cycle 2, result_o=0xFFFFFFFF. REMU 7/0 -> 7. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, fin at cycle 2. REM same operands -> 0.
- REM rs1=0xFFFFFFF9 (-7), rs2=2 -> result 0xFFFFFFFF. DIV same operands -> 0xFFFFFFFD.
- Flush mid-operation:
  - flush_i pulse at cycle 10 of a DIVU -> state IDLE next cycle, no fin_o, result_o retains its previous value.
  - A following DIVU 100/7 -> 14.
- Boundary cases:
  - flush_i coincident with the DONE cycle -> fin_o=0.
  - rstn low at cycle 20 of a MUL -> all outputs 0 next cycle, no fin.
  - Back-to-back MUL, start re-asserted the cycle after fin_o -> second fin_o 35 cycles later.
